// File: rtl/mem_responder_pkg.sv
// Shared widths, FSM state and operation encodings for the memory responder.
package mem_responder_pkg;

   localparam int MEM_ADDR_W = 8;
   localparam int MEM_DATA_W = 16;
   localparam int MEM_CNT_W  = 4;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_WAIT = 2'd1,
      MEM_RESP = 2'd2
   } mem_state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } mem_op_e;

   // Wait-state count as loaded into the down-counter; only 0..15 is meaningful.
   function automatic logic [MEM_CNT_W-1:0] wait_load(input int wait_cycles);
      return MEM_CNT_W'(wait_cycles);
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response and preload signals between a requester and the memory responder.
interface mem_responder_if
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
);

   logic [ADDR_W-1:0] i_mar_addr;
   logic [DATA_W-1:0] i_mbr_wdata;
   logic              i_rd_req;
   logic              i_wr_req;
   logic              i_load_en;
   logic [ADDR_W-1:0] i_load_addr;
   logic [DATA_W-1:0] i_load_data;
   logic [DATA_W-1:0] o_mem_data_bus;
   logic              o_ready;
   logic              o_busy;

   modport master (
      output i_mar_addr, i_mbr_wdata, i_rd_req, i_wr_req,
             i_load_en, i_load_addr, i_load_data,
      input  o_mem_data_bus, o_ready, o_busy
   );

   modport slave (
      input  i_mar_addr, i_mbr_wdata, i_rd_req, i_wr_req,
             i_load_en, i_load_addr, i_load_data,
      output o_mem_data_bus, o_ready, o_busy
   );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port main memory: synchronous write, combinational read, contents survive reset.
module mem_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   // Storage write; deliberately not reset so preloaded contents persist.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read/write, inserts wait states, then
// pulses o_ready for one cycle (with read data on the bus for reads).
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  MEM_IDLE | accepting requests or preloads, bus idle
//  MEM_WAIT | request latched, wait-state counter running down
//  MEM_RESP | one-cycle response: o_ready high, read data on the bus
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W      = MEM_ADDR_W,
   parameter int DATA_W      = MEM_DATA_W,
   parameter int WAIT_CYCLES = 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   mem_responder_if.slave  bus
);

   localparam logic [MEM_CNT_W-1:0] WAIT_LD = wait_load(WAIT_CYCLES);

   mem_state_e             state_q, state_d;
   logic [MEM_CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   mem_op_e                op_q, op_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic                   ready_q, ready_d;
   logic                   busy_q, busy_d;

   logic                   req;
   logic                   load_hit;
   logic                   enter_resp;
   logic                   mem_we;
   logic [ADDR_W-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_wdata;
   logic [DATA_W-1:0]      mem_rdata;

   assign req = bus.i_rd_req | bus.i_wr_req;

   // State, request latches and registered outputs; memory is not touched by reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= MEM_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         op_q    <= OP_RD;
         data_q  <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         op_q    <= op_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state, counter and latch updates; write beats read when both are raised.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      op_d    = op_q;
      unique case (state_q)
         MEM_IDLE: begin
            if (req) begin
               addr_d  = bus.i_mar_addr;
               wdata_d = bus.i_mbr_wdata;
               op_d    = bus.i_wr_req ? OP_WR : OP_RD;
               cnt_d   = WAIT_LD;
               state_d = (WAIT_CYCLES == 0) ? MEM_RESP : MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = MEM_RESP;
            end
         end
         MEM_RESP: begin
            state_d = MEM_IDLE;
         end
         default: begin
            state_d = MEM_IDLE;
         end
      endcase
   end

   // Memory port sharing and output next-values. addr_d/wdata_d/op_d already hold the
   // incoming request when jumping IDLE->RESP, so the zero-wait case needs no special path.
   always_comb begin
      load_hit   = (state_q == MEM_IDLE) && bus.i_load_en && !req;
      enter_resp = (state_d == MEM_RESP);
      mem_we     = load_hit || (enter_resp && (op_d == OP_WR));
      mem_addr   = load_hit ? bus.i_load_addr : addr_d;
      mem_wdata  = load_hit ? bus.i_load_data : wdata_d;
      ready_d    = enter_resp;
      busy_d     = (state_d != MEM_IDLE);
      data_d     = (enter_resp && (op_d == OP_RD)) ? mem_rdata : '0;
   end

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem_array (
      .i_clk   (i_clk),
      .i_we    (mem_we),
      .i_addr  (mem_addr),
      .i_wdata (mem_wdata),
      .o_rdata (mem_rdata)
   );

   assign bus.o_mem_data_bus = data_q;
   assign bus.o_ready        = ready_q;
   assign bus.o_busy         = busy_q;

endmodule
